adbg_wb_slv_biu: RTL and testbench

//  Wishbone B3 classic slave that forwards single WB accesses to a debug-side request port in biu_clk.

---
 rtl/adbg_wb_slv_pkg.sv | 16 +
 rtl/adbg_toggle_sync.sv | 41 ++++
 rtl/adbg_wb_slv_biu.sv | 206 ++++++++++++++++++++
 tb/tb_adbg_wb_slv_biu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_wb_slv_pkg.sv
// Shared state encodings for the Wishbone-slave debug BIU.
package adbg_wb_slv_pkg;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WAIT,
        WB_RESP,
        WB_DRAIN
    } wb_state_t;

    typedef enum logic {
        BIU_IDLE,
        BIU_BUSY
    } biu_state_t;

endpackage

// File: rtl/adbg_toggle_sync.sv
// Multi-flop synchronizer: toggle-to-pulse converter, or reset synchronizer
// (async assert, SYNC_STAGES-edge deassert) when RESET_SYNC is set.
module adbg_toggle_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_SYNC  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    generate
        if (RESET_SYNC) begin : g_rst
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= '1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
                end
            end
            assign q = sync_reg[SYNC_STAGES-1];
        end else begin : g_tgl
            logic prev_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= '0;
                    prev_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
                    prev_reg <= sync_reg[SYNC_STAGES-1];
                end
            end
            // One-cycle pulse on every level change of the synchronized toggle.
            assign q = sync_reg[SYNC_STAGES-1] ^ prev_reg;
        end
    endgenerate

endmodule

// File: rtl/adbg_wb_slv_biu.sv
// Wishbone classic slave forwarding single accesses to a debug request port
// in biu_clk, with toggle-handshake crossings and one access in flight.
module adbg_wb_slv_biu
    import adbg_wb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    biu_clk,
    input  logic                    biu_rst,
    input  logic                    wb_clk_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    biu_strb,
    output logic                    biu_we,
    output logic [ADDR_WIDTH-1:0]   biu_addr,
    output logic [DATA_WIDTH/8-1:0] biu_sel,
    output logic [DATA_WIDTH-1:0]   biu_do,
    input  logic [DATA_WIDTH-1:0]   biu_di,
    input  logic                    biu_ack,
    input  logic                    biu_err
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic wb_rst;
    logic req_pulse;
    logic rsp_pulse;

    // WB-domain state
    wb_state_t             wb_state_reg, wb_state_next;
    logic                  req_tgl_reg;
    logic                  hold_we_reg;
    logic [ADDR_WIDTH-1:0] hold_addr_reg;
    logic [SEL_WIDTH-1:0]  hold_sel_reg;
    logic [DATA_WIDTH-1:0] hold_do_reg;
    logic                  wb_ack_reg, wb_ack_next;
    logic                  wb_err_reg, wb_err_next;
    logic [DATA_WIDTH-1:0] wb_dat_reg;
    logic                  accept;
    logic                  load_dat;

    // Debug-domain state
    biu_state_t            biu_state_reg, biu_state_next;
    logic                  rsp_tgl_reg;
    logic                  rsp_err_reg;
    logic [DATA_WIDTH-1:0] rsp_dat_reg;
    logic                  biu_strb_reg;
    logic                  biu_we_reg;
    logic [ADDR_WIDTH-1:0] biu_addr_reg;
    logic [SEL_WIDTH-1:0]  biu_sel_reg;
    logic [DATA_WIDTH-1:0] biu_do_reg;
    logic                  launch;
    logic                  finish;

    adbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_SYNC(1'b1)) u_rst_sync (
        .clk (wb_clk_i),
        .rst (biu_rst),
        .d   (1'b0),
        .q   (wb_rst)
    );

    adbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_SYNC(1'b0)) u_req_sync (
        .clk (biu_clk),
        .rst (biu_rst),
        .d   (req_tgl_reg),
        .q   (req_pulse)
    );

    adbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_SYNC(1'b0)) u_rsp_sync (
        .clk (wb_clk_i),
        .rst (wb_rst),
        .d   (rsp_tgl_reg),
        .q   (rsp_pulse)
    );

    // ---------------- Wishbone side ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst) begin
        if (wb_rst) wb_state_reg <= WB_IDLE;
        else        wb_state_reg <= wb_state_next;
    end

    always_comb begin
        wb_state_next = wb_state_reg;
        case (wb_state_reg)
            WB_IDLE:  if (wb_cyc_i && wb_stb_i) wb_state_next = WB_WAIT;
            WB_WAIT: begin
                if (rsp_pulse)      wb_state_next = (wb_cyc_i && wb_stb_i) ? WB_RESP : WB_IDLE;
                else if (!wb_cyc_i) wb_state_next = WB_DRAIN;
            end
            WB_RESP:  wb_state_next = WB_IDLE;
            WB_DRAIN: if (rsp_pulse) wb_state_next = WB_IDLE;
            default:  wb_state_next = WB_IDLE;
        endcase
    end

    // rsp_err_reg/rsp_dat_reg are stable once the response toggle is seen.
    always_comb begin
        accept      = 1'b0;
        wb_ack_next = 1'b0;
        wb_err_next = 1'b0;
        load_dat    = 1'b0;
        case (wb_state_reg)
            WB_IDLE: accept = wb_cyc_i && wb_stb_i;
            WB_WAIT: begin
                if (rsp_pulse && wb_cyc_i && wb_stb_i) begin
                    wb_ack_next = !rsp_err_reg;
                    wb_err_next = rsp_err_reg;
                    load_dat    = !hold_we_reg && !rsp_err_reg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst) begin
        if (wb_rst) begin
            req_tgl_reg   <= 1'b0;
            hold_we_reg   <= 1'b0;
            hold_addr_reg <= '0;
            hold_sel_reg  <= '0;
            hold_do_reg   <= '0;
            wb_ack_reg    <= 1'b0;
            wb_err_reg    <= 1'b0;
            wb_dat_reg    <= '0;
        end else begin
            wb_ack_reg <= wb_ack_next;
            wb_err_reg <= wb_err_next;
            if (load_dat) wb_dat_reg <= rsp_dat_reg;
            if (accept) begin
                req_tgl_reg   <= ~req_tgl_reg;
                hold_we_reg   <= wb_we_i;
                hold_addr_reg <= wb_adr_i;
                hold_sel_reg  <= wb_sel_i;
                hold_do_reg   <= wb_dat_i;
            end
        end
    end

    assign wb_dat_o = wb_dat_reg;
    assign wb_ack_o = wb_ack_reg;
    assign wb_err_o = wb_err_reg;

    // ---------------- Debug side ----------------
    always_ff @(posedge biu_clk or posedge biu_rst) begin
        if (biu_rst) biu_state_reg <= BIU_IDLE;
        else         biu_state_reg <= biu_state_next;
    end

    always_comb begin
        biu_state_next = biu_state_reg;
        case (biu_state_reg)
            BIU_IDLE: if (req_pulse) biu_state_next = BIU_BUSY;
            BIU_BUSY: if (biu_ack)   biu_state_next = BIU_IDLE;
            default:  biu_state_next = BIU_IDLE;
        endcase
    end

    always_comb begin
        launch = (biu_state_reg == BIU_IDLE) && req_pulse;
        finish = (biu_state_reg == BIU_BUSY) && biu_ack;
    end

    // Hold registers are read here without synchronizers: they settled
    // SYNC_STAGES+1 edges before the request pulse reaches this domain.
    always_ff @(posedge biu_clk or posedge biu_rst) begin
        if (biu_rst) begin
            biu_strb_reg <= 1'b0;
            biu_we_reg   <= 1'b0;
            biu_addr_reg <= '0;
            biu_sel_reg  <= '0;
            biu_do_reg   <= '0;
            rsp_tgl_reg  <= 1'b0;
            rsp_err_reg  <= 1'b0;
            rsp_dat_reg  <= '0;
        end else begin
            if (launch) begin
                biu_strb_reg <= 1'b1;
                biu_we_reg   <= hold_we_reg;
                biu_addr_reg <= hold_addr_reg;
                biu_sel_reg  <= hold_sel_reg;
                biu_do_reg   <= hold_do_reg;
            end else if (finish) begin
                biu_strb_reg <= 1'b0;
                rsp_tgl_reg  <= ~rsp_tgl_reg;
                rsp_err_reg  <= biu_err;
                if (!biu_we_reg) rsp_dat_reg <= biu_di;
            end
        end
    end

    assign biu_strb = biu_strb_reg;
    assign biu_we   = biu_we_reg;
    assign biu_addr = biu_addr_reg;
    assign biu_sel  = biu_sel_reg;
    assign biu_do   = biu_do_reg;

endmodule

// File: tb/tb_adbg_wb_slv_biu.sv
// Bench for adbg_wb_slv_biu: table-driven vectors, a queued debug-side
// responder, abort / reset corner cases and random traffic at two clock ratios.
module tb_adbg_wb_slv_biu;

    localparam int SS = 2;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] di;
        logic        err;
        int          delay;
    } req_t;

    typedef struct {
        req_t        r;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    logic        biu_clk = 1'b0;
    logic        wb_clk  = 1'b0;
    logic        biu_rst = 1'b1;
    logic        wb_cyc  = 1'b0;
    logic        wb_stb  = 1'b0;
    logic        wb_we   = 1'b0;
    logic [31:0] wb_adr  = '0;
    logic [3:0]  wb_sel  = '0;
    logic [31:0] wb_dat  = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        biu_strb;
    logic        biu_we;
    logic [31:0] biu_addr;
    logic [3:0]  biu_sel;
    logic [31:0] biu_do;
    logic [31:0] biu_di  = '0;
    logic        biu_ack = 1'b0;
    logic        biu_err = 1'b0;

    int wb_half  = 5;
    int biu_half = 50;

    int vec_cnt    = 0;
    int miscnt     = 0;
    int ack_pulses = 0;
    int err_pulses = 0;

    req_t req_q[$];

    initial forever #(wb_half) wb_clk = ~wb_clk;
    initial forever #(biu_half) biu_clk = ~biu_clk;

    adbg_wb_slv_biu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SYNC_STAGES(SS)) dut (
        .biu_clk  (biu_clk),
        .biu_rst  (biu_rst),
        .wb_clk_i (wb_clk),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_we_i  (wb_we),
        .wb_adr_i (wb_adr),
        .wb_sel_i (wb_sel),
        .wb_dat_i (wb_dat),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .biu_strb (biu_strb),
        .biu_we   (biu_we),
        .biu_addr (biu_addr),
        .biu_sel  (biu_sel),
        .biu_do   (biu_do),
        .biu_di   (biu_di),
        .biu_ack  (biu_ack),
        .biu_err  (biu_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                    input logic [31:0] dat, input logic [31:0] di, input logic err,
                                    input int delay);
        req_t r;
        r.we = we; r.adr = adr; r.sel = sel; r.dat = dat;
        r.di = di; r.err = err; r.delay = delay;
        return r;
    endfunction

    // Every response cycle: ack/err exclusive and only inside cyc&stb.
    always @(negedge wb_clk) begin
        if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
            if (wb_ack_o === 1'b1) ack_pulses++;
            if (wb_err_o === 1'b1) err_pulses++;
            chk("ack_err_exclusive", 64'(wb_ack_o & wb_err_o), 64'd0);
            chk("resp_inside_cycle", 64'(wb_cyc & wb_stb), 64'd1);
        end
    end

    // Debug-side responder: pops the expected request, checks it, acks after r.delay cycles.
    initial begin : responder
        req_t r;
        int   wcnt;
        bit   active;
        active = 1'b0;
        wcnt   = 0;
        forever begin
            @(negedge biu_clk);
            if (biu_ack) begin
                biu_ack = 1'b0;
                biu_err = 1'b0;
            end
            if (biu_rst) begin
                active = 1'b0;
            end else if (active) begin
                wcnt++;
                if (wcnt >= r.delay) begin
                    biu_ack = 1'b1;
                    biu_err = r.err;
                    biu_di  = r.di;
                    active  = 1'b0;
                end
            end else if (biu_strb) begin
                if (req_q.size() == 0) begin
                    vec_cnt++;
                    miscnt++;
                    $display("FAIL unexpected_strb: got strobe addr 0x%08h, required no request", biu_addr);
                    active = 1'b0;
                end else begin
                    r = req_q.pop_front();
                    chk("req_we_sel_addr", {27'd0, biu_we, biu_sel, biu_addr}, {27'd0, r.we, r.sel, r.adr});
                    if (r.we) chk("req_wdata", 64'(biu_do), 64'(r.dat));
                    wcnt   = 0;
                    active = 1'b1;
                end
            end
        end
    end

    task automatic wb_access(input req_t r, input int budget,
                             output logic got_ack, output logic got_err, output logic [31:0] rdat);
        int n;
        req_q.push_back(r);
        @(posedge wb_clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = r.we;
        wb_adr = r.adr; wb_sel = r.sel; wb_dat = r.dat;
        got_ack = 1'b0; got_err = 1'b0; rdat = '0;
        n = 0;
        while (n < budget) begin
            @(negedge wb_clk);
            n++;
            if (wb_ack_o || wb_err_o) begin
                got_ack = wb_ack_o;
                got_err = wb_err_o;
                rdat    = wb_dat_o;
                break;
            end
        end
        chk("resp_seen", 64'(got_ack | got_err), 64'd1);
        @(posedge wb_clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic run_vec(input string tag, input req_t r, input logic exp_ack,
                           input logic exp_err, input logic [31:0] exp_dat);
        logic        ga, ge;
        logic [31:0] rd;
        int          p0;
        p0 = ack_pulses + err_pulses;
        wb_access(r, 400, ga, ge, rd);
        repeat (3) @(negedge wb_clk);
        chk({tag, "_ack"}, 64'(ga), 64'(exp_ack));
        chk({tag, "_err"}, 64'(ge), 64'(exp_err));
        chk({tag, "_dat"}, 64'(rd), 64'(exp_dat));
        chk({tag, "_pulses"}, 64'(ack_pulses + err_pulses - p0), 64'd1);
        $display("txn %s we=%0d adr=%08h sel=%h ack=%0d err=%0d dat=%08h", tag, r.we, r.adr, r.sel, ga, ge, rd);
    endtask

    task automatic do_reset();
        biu_rst = 1'b1;
        wb_cyc  = 1'b0;
        wb_stb  = 1'b0;
        repeat (4) @(posedge biu_clk);
        repeat (2) @(posedge wb_clk);
        #1;
        req_q.delete();
        biu_rst = 1'b0;
        repeat (SS + 3) @(posedge wb_clk);
        repeat (2) @(posedge biu_clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wb_dat_o"}, 64'(wb_dat_o), 64'd0);
        chk({tag, "_wb_ack_o"}, 64'(wb_ack_o), 64'd0);
        chk({tag, "_wb_err_o"}, 64'(wb_err_o), 64'd0);
        chk({tag, "_biu_strb"}, 64'(biu_strb), 64'd0);
        chk({tag, "_biu_we"},   64'(biu_we),   64'd0);
        chk({tag, "_biu_addr"}, 64'(biu_addr), 64'd0);
        chk({tag, "_biu_sel"},  64'(biu_sel),  64'd0);
        chk({tag, "_biu_do"},   64'(biu_do),   64'd0);
    endtask

    task automatic random_phase(input string tag, input int n);
        logic [31:0] model;
        req_t        r;
        model = 32'h0;
        for (int i = 0; i < n; i++) begin
            r = mk_req(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)),
                       $urandom, $urandom, ($urandom_range(0, 7) == 0), int'($urandom_range(1, 4)));
            if (!r.we && !r.err) model = r.di;
            run_vec(tag, r, !r.err, r.err, model);
        end
    endtask

    initial begin : watchdog
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[6];
        int   p0;
        int   n;

        tbl[0].r = mk_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 3);
        tbl[0].exp_ack = 1'b1; tbl[0].exp_err = 1'b0; tbl[0].exp_dat = 32'h0;
        tbl[1].r = mk_req(1'b0, 32'h24, 4'h3, 32'h0,        32'h0000A5A5, 1'b0, 3);
        tbl[1].exp_ack = 1'b1; tbl[1].exp_err = 1'b0; tbl[1].exp_dat = 32'h0000A5A5;
        tbl[2].r = mk_req(1'b0, 32'h28, 4'hF, 32'h0,        32'h12345678, 1'b1, 5);
        tbl[2].exp_ack = 1'b0; tbl[2].exp_err = 1'b1; tbl[2].exp_dat = 32'h0000A5A5;
        tbl[3].r = mk_req(1'b1, 32'h2C, 4'h1, 32'h00000011, 32'h0,        1'b1, 1);
        tbl[3].exp_ack = 1'b0; tbl[3].exp_err = 1'b1; tbl[3].exp_dat = 32'h0000A5A5;
        tbl[4].r = mk_req(1'b0, 32'h00, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0, 1);
        tbl[4].exp_ack = 1'b1; tbl[4].exp_err = 1'b0; tbl[4].exp_dat = 32'hCAFEF00D;
        tbl[5].r = mk_req(1'b1, 32'h3C, 4'hC, 32'h00000000, 32'h0,        1'b0, 8);
        tbl[5].exp_ack = 1'b1; tbl[5].exp_err = 1'b0; tbl[5].exp_dat = 32'hCAFEF00D;

        // wb_clk 100 MHz, biu_clk 10 MHz
        do_reset();
        chk_reset_outputs("reset");

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].r, tbl[i].exp_ack, tbl[i].exp_err, tbl[i].exp_dat);
        end

        // Abort: cyc drops two cycles after stb, then a new access must wait for the drain.
        p0 = ack_pulses + err_pulses;
        req_q.push_back(mk_req(1'b0, 32'h34, 4'hF, 32'h0, 32'h99999999, 1'b0, 6));
        @(posedge wb_clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h34; wb_sel = 4'hF;
        repeat (2) @(posedge wb_clk);
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        run_vec("after_abort", mk_req(1'b0, 32'h30, 4'hF, 32'h0, 32'h0000BEEF, 1'b0, 2), 1'b1, 1'b0, 32'h0000BEEF);
        chk("abort_total_pulses", 64'(ack_pulses + err_pulses - p0), 64'd1);

        // Reset while the debug side is busy with a long access.
        p0 = ack_pulses + err_pulses;
        req_q.push_back(mk_req(1'b0, 32'h08, 4'hF, 32'h0, 32'h88888888, 1'b0, 30));
        @(posedge wb_clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h08; wb_sel = 4'hF;
        n = 0;
        while (biu_strb !== 1'b1 && n < 400) begin
            @(negedge wb_clk);
            n++;
        end
        chk("rst_reach_busy", 64'(biu_strb), 64'd1);
        biu_rst = 1'b1;
        #2;
        chk_reset_outputs("midrst");
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (3) @(posedge biu_clk);
        #1;
        req_q.delete();
        biu_rst = 1'b0;
        repeat (SS + 4) @(posedge wb_clk);
        chk("midrst_no_resp", 64'(ack_pulses + err_pulses - p0), 64'd0);
        run_vec("post_rst", mk_req(1'b0, 32'h04, 4'hF, 32'h0, 32'h00000444, 1'b0, 2), 1'b1, 1'b0, 32'h00000444);

        do_reset();
        random_phase("rndA", 100);

        // wb_clk 10 MHz, biu_clk 100 MHz
        biu_rst = 1'b1;
        wb_half  = 50;
        biu_half = 5;
        do_reset();
        random_phase("rndB", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscnt);
        $finish;
    end

endmodule
